// File: rtl/vedic_div_pkg.sv
// Shared definitions for the 16/8 restoring divider.
// Contents: operand widths, the last iteration index, and the FSM state type.
package vedic_div_pkg;

  localparam int DIVIDEND_W = 16;
  localparam int DIVISOR_W  = 8;

  // The counter runs 0..ITER_LAST, one quotient bit per value.
  localparam logic [3:0] ITER_LAST = 4'd15;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_e;

endpackage

// File: rtl/vedic_div_step.sv
// One combinational restoring-division step.
// Ports:
//   rem_in   - 9-bit partial remainder from the previous step
//   bit_in   - next dividend bit (MSB first)
//   div      - 8-bit divisor
//   rem_out  - partial remainder after this step
//   q_bit    - quotient bit resolved by this step
module vedic_div_step
  import vedic_div_pkg::*;
(
  input  logic [8:0]           rem_in,
  input  logic                 bit_in,
  input  logic [DIVISOR_W-1:0] div,
  output logic [8:0]           rem_out,
  output logic                 q_bit
);

  logic [8:0] p;
  logic       ge;

  always_comb begin
    p  = {rem_in[7:0], bit_in};
    // rem_in[8] stays clear while rem < div holds; if it were ever set the
    // shifted value is certainly >= div, so it forces a subtract.
    ge = rem_in[8] | (p >= {1'b0, div});
    rem_out = ge ? (p - {1'b0, div}) : p;
    q_bit   = ge;
  end

endmodule

// File: rtl/vedic_div_16x8.sv
// Sequential restoring divider: 16-bit dividend / 8-bit divisor, one
// quotient bit per clock, behind a start/busy/done handshake.
// Ports:
//   clk, rst     - clock, asynchronous active-high reset
//   start        - request a division (ignored while busy)
//   a, b         - dividend, divisor (latched on accept)
//   busy         - iteration in progress
//   done         - one-cycle pulse when q/r/dz update
//   q, r         - quotient, remainder (held until the next done)
//   dz           - divide-by-zero flag, valid with done
// Build option: define VEDIC_DIV_ZERO_CHECK_EN to short-circuit b==0 to an
// immediate result with dz=1; otherwise b==0 runs all 16 iterations and
// dz is tied low.
module vedic_div_16x8
  import vedic_div_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [DIVIDEND_W-1:0] a,
  input  logic [DIVISOR_W-1:0]  b,
  output logic                  busy,
  output logic                  done,
  output logic [DIVIDEND_W-1:0] q,
  output logic [DIVISOR_W-1:0]  r,
  output logic                  dz
);

  state_e                state_q, state_d;
  logic [3:0]            count_q, count_d;
  // Dividend bits shift out of the top while quotient bits shift in below.
  logic [DIVIDEND_W-1:0] dvd_q, dvd_d;
  logic [8:0]            rem_q, rem_d;
  logic [DIVISOR_W-1:0]  div_q, div_d;
  logic [DIVIDEND_W-1:0] q_q, q_d;
  logic [DIVISOR_W-1:0]  r_q, r_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
`ifdef VEDIC_DIV_ZERO_CHECK_EN
  logic                  dz_q, dz_d;
`endif

  logic [8:0] rem_next;
  logic       q_bit;

  vedic_div_step u_step (
    .rem_in  (rem_q),
    .bit_in  (dvd_q[DIVIDEND_W-1]),
    .div     (div_q),
    .rem_out (rem_next),
    .q_bit   (q_bit)
  );

  // NOTE: every _d gets a default first so no path through the case
  // leaves a variable unassigned, which would infer a latch.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    dvd_d   = dvd_q;
    rem_d   = rem_q;
    div_d   = div_q;
    q_d     = q_q;
    r_d     = r_q;
    busy_d  = 1'b0;
    done_d  = 1'b0;
`ifdef VEDIC_DIV_ZERO_CHECK_EN
    dz_d    = dz_q;
`endif

    case (state_q)
      IDLE, FIN: begin
        if (start) begin
          dvd_d   = a;
          div_d   = b;
          rem_d   = '0;
          count_d = '0;
          state_d = RUN;
          busy_d  = 1'b1;
`ifdef VEDIC_DIV_ZERO_CHECK_EN
          if (b == '0) begin
            state_d = FIN;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            q_d     = '1;
            r_d     = a[DIVISOR_W-1:0];
            dz_d    = 1'b1;
          end
`endif
        end else begin
          state_d = IDLE;
        end
      end

      RUN: begin
        busy_d  = 1'b1;
        dvd_d   = {dvd_q[DIVIDEND_W-2:0], q_bit};
        rem_d   = rem_next;
        count_d = count_q + 4'd1;
        if (count_q == ITER_LAST) begin
          // Results come straight from the last step so they land on the
          // same edge that enters FIN.
          state_d = FIN;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          q_d     = {dvd_q[DIVIDEND_W-2:0], q_bit};
          r_d     = rem_next[DIVISOR_W-1:0];
`ifdef VEDIC_DIV_ZERO_CHECK_EN
          dz_d    = 1'b0;
`endif
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      count_q <= '0;
      dvd_q   <= '0;
      rem_q   <= '0;
      div_q   <= '0;
      q_q     <= '0;
      r_q     <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef VEDIC_DIV_ZERO_CHECK_EN
      dz_q    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      dvd_q   <= dvd_d;
      rem_q   <= rem_d;
      div_q   <= div_d;
      q_q     <= q_d;
      r_q     <= r_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef VEDIC_DIV_ZERO_CHECK_EN
      dz_q    <= dz_d;
`endif
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign q    = q_q;
  assign r    = r_q;
`ifdef VEDIC_DIV_ZERO_CHECK_EN
  assign dz   = dz_q;
`else
  assign dz   = 1'b0;
`endif

endmodule

// File: tb/tb_vedic_div_16x8.sv
// Self-checking bench for vedic_div_16x8: table of directed divisions plus
// hand-written sequences for ignored start, mid-run reset and back-to-back.
module tb_vedic_div_16x8;

  logic        clk;
  logic        rst;
  logic        start;
  logic [15:0] a;
  logic [7:0]  b;
  logic        busy;
  logic        done;
  logic [15:0] q;
  logic [7:0]  r;
  logic        dz;

  int errors = 0;
  int checks = 0;

  vedic_div_16x8 dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .q     (q),
    .r     (r),
    .dz    (dz)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] a;
    logic [7:0]  b;
    logic [15:0] q;
    logic [7:0]  r;
    logic        dz;
    int          lat;
  } vec_t;

  localparam int NVEC = 10;
  vec_t vecs[NVEC];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // Called at a negedge: drive a request, let edge N sample it, drop start.
  task automatic launch(input logic [15:0] av, input logic [7:0] bv);
    a = av;
    b = bv;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
  endtask

  // Called at the negedge after edge N. lat counts edges from N (inclusive)
  // to the one that raised done; 0 means no done within the budget.
  task automatic wait_done(output int lat, output logic overlap);
    int n;
    n = 1;
    overlap = 1'b0;
    lat = 0;
    while (n <= 40) begin
      if (busy && done) overlap = 1'b1;
      if (done) begin
        lat = n;
        break;
      end
      @(posedge clk);
      @(negedge clk);
      n++;
    end
  endtask

  initial begin
    int   lat;
    logic ov;

    vecs[0] = '{16'd38000, 8'd190, 16'd200,   8'd0,    1'b0, 17};
    vecs[1] = '{16'd65535, 8'd255, 16'd257,   8'd0,    1'b0, 17};
    vecs[2] = '{16'd1000,  8'd3,   16'd333,   8'd1,    1'b0, 17};
`ifdef VEDIC_DIV_ZERO_CHECK_EN
    vecs[3] = '{16'h1234,  8'd0,   16'hFFFF,  8'h34,   1'b1, 1};
`else
    vecs[3] = '{16'h1234,  8'd0,   16'hFFFF,  8'h34,   1'b0, 17};
`endif
    vecs[4] = '{16'd0,     8'd1,   16'd0,     8'd0,    1'b0, 17};
    vecs[5] = '{16'd65535, 8'd1,   16'd65535, 8'd0,    1'b0, 17};
    vecs[6] = '{16'd7,     8'd200, 16'd0,     8'd7,    1'b0, 17};
    vecs[7] = '{16'd255,   8'd16,  16'd15,    8'd15,   1'b0, 17};
    vecs[8] = '{16'd65535, 8'd128, 16'd511,   8'd127,  1'b0, 17};
    vecs[9] = '{16'd100,   8'd7,   16'd14,    8'd2,    1'b0, 17};

    rst = 1'b1;
    start = 1'b0;
    a = '0;
    b = '0;
    @(negedge clk);
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_done", {31'd0, done}, 32'd0);
    check("reset_q",    {16'd0, q},    32'd0);
    check("reset_r",    {24'd0, r},    32'd0);
    check("reset_dz",   {31'd0, dz},   32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Table-driven divisions, idle gap between each.
    for (int i = 0; i < NVEC; i++) begin
      launch(vecs[i].a, vecs[i].b);
      check($sformatf("v%0d_busy_after_start", i), {31'd0, busy}, (vecs[i].lat == 1) ? 32'd0 : 32'd1);
      wait_done(lat, ov);
      check($sformatf("v%0d_latency", i), lat, vecs[i].lat);
      check($sformatf("v%0d_q", i), {16'd0, q}, {16'd0, vecs[i].q});
      check($sformatf("v%0d_r", i), {24'd0, r}, {24'd0, vecs[i].r});
      check($sformatf("v%0d_dz", i), {31'd0, dz}, {31'd0, vecs[i].dz});
      check($sformatf("v%0d_busy_done_overlap", i), {31'd0, ov}, 32'd0);
      @(negedge clk);
      check($sformatf("v%0d_done_one_cycle", i), {31'd0, done}, 32'd0);
      check($sformatf("v%0d_q_held", i), {16'd0, q}, {16'd0, vecs[i].q});
    end

    // start mid-run is ignored and operand changes do not disturb the run.
    launch(16'd12816, 8'd89);
    repeat (4) begin
      @(posedge clk);
      @(negedge clk);
    end
    a = 16'd1;
    b = 8'd1;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    begin
      int n;
      n = 6;
      lat = 0;
      while (n <= 40) begin
        if (done) begin
          lat = n;
          break;
        end
        @(posedge clk);
        @(negedge clk);
        n++;
      end
    end
    check("ignore_latency", lat, 17);
    check("ignore_q", {16'd0, q}, 32'd144);
    check("ignore_r", {24'd0, r}, 32'd0);
    @(negedge clk);
    check("ignore_no_rerun_busy", {31'd0, busy}, 32'd0);

    // Asynchronous reset after 8 iterations clears outputs immediately.
    launch(16'd1000, 8'd3);
    repeat (8) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("midrst_busy", {31'd0, busy}, 32'd0);
    check("midrst_done", {31'd0, done}, 32'd0);
    check("midrst_q",    {16'd0, q},    32'd0);
    check("midrst_r",    {24'd0, r},    32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    launch(16'd100, 8'd7);
    wait_done(lat, ov);
    check("after_rst_latency", lat, 17);
    check("after_rst_q", {16'd0, q}, 32'd14);
    check("after_rst_r", {24'd0, r}, 32'd2);

    // Back-to-back: start in the FIN cycle of the previous division.
    @(negedge clk);
    launch(16'd38000, 8'd190);
    wait_done(lat, ov);
    check("b2b_first_q", {16'd0, q}, 32'd200);
    launch(16'd255, 8'd16);
    check("b2b_busy", {31'd0, busy}, 32'd1);
    check("b2b_done_low", {31'd0, done}, 32'd0);
    check("b2b_q_held", {16'd0, q}, 32'd200);
    wait_done(lat, ov);
    check("b2b_latency", lat, 17);
    check("b2b_q", {16'd0, q}, 32'd15);
    check("b2b_r", {24'd0, r}, 32'd15);
    check("b2b_overlap", {31'd0, ov}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
